// File: rtl/dp_pkg.sv
// Purpose: shared width math and lane helpers for the pipelined adder tree.
// Latency: none (package of constant functions and macros).
// Backpressure: not applicable.
`ifndef DP_PKG_SV
`define DP_PKG_SV

// Lane idx of a packed multi-lane bus, each lane w bits wide.
`define DP_LANE(bus, idx, w) bus[(idx)*(w) +: (w)]

// Elaboration-time guard: the result must hold the worst-case tree sum.
`define DP_CHECK_OUT_W(out_w, in_w, levels) if ((out_w) < (in_w) + (levels)) begin : g_out_w_too_small $error("pipelined_sum_tree: OUT_W must be >= IN_W + LEVELS"); end

package dp_pkg;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

  // Number of lanes entering tree level k when the tree starts with n lanes.
  function automatic int lanes_at_level(input int n, input int k);
    int c;
    c = n;
    for (int j = 0; j < k; j++) begin
      c = (c + 1) / 2;
    end
    return c;
  endfunction

  // Lane offset of level k inside a flat node array holding every level back to back.
  function automatic int level_offset(input int n, input int k);
    int o;
    o = 0;
    for (int j = 0; j < k; j++) begin
      o = o + lanes_at_level(n, j);
    end
    return o;
  endfunction

endpackage

`endif

// File: rtl/sum_tree_level.sv
// Purpose: one adder-tree level; sums lane pairs, an odd leftover lane passes through.
// Latency: 1 cycle, everything registered.
// Backpressure: none; accepts a beat every cycle, bubbles propagate as valid=0.
module sum_tree_level #(
  parameter int N_IN   = 2,
  parameter int W      = 32,
  parameter int SIDE_W = 2,
  localparam int N_OUT = (N_IN + 1) / 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [N_IN*W-1:0]   in_data,
  input  logic [SIDE_W-1:0]   in_side,
  output logic                out_valid,
  output logic [N_OUT*W-1:0]  out_data,
  output logic [SIDE_W-1:0]   out_side
);

  logic [N_OUT*W-1:0] nxt;

  // Pairwise sums; lanes are already wide enough that no carry can be lost.
  always_comb begin
    nxt = '0;
    for (int j = 0; j < N_IN / 2; j++) begin
      nxt[j*W +: W] = in_data[(2*j)*W +: W] + in_data[(2*j+1)*W +: W];
    end
    if (N_IN % 2 == 1) begin
      nxt[(N_OUT-1)*W +: W] = in_data[(N_IN-1)*W +: W];
    end
  end

  // Register the level; data and sideband only load on a real beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_side  <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= nxt;
        out_side <= in_side;
      end
    end
  end

endmodule

// File: rtl/pipelined_sum_tree.sv
// Purpose: masked unsigned adder tree with optional saturating running accumulate.
// Latency: clog2(NUM_IN) tree stages + 1 output stage (5 cycles for 16 lanes).
// Backpressure: none; one beat per cycle, bubbles give out_valid=0 and hold outputs.
module pipelined_sum_tree
  import dp_pkg::*;
#(
  parameter int NUM_IN = 16,
  parameter int IN_W   = 8,
  parameter int OUT_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [NUM_IN*IN_W-1:0] in_data,
  input  logic [NUM_IN-1:0]      in_mask,
  input  logic                   acc_mode,
  input  logic                   acc_clr,
  output logic                   out_valid,
  output logic [OUT_W-1:0]       sum_out,
  output logic                   ovf
);

  localparam int LEVELS = clog2(NUM_IN);
  // Every level's lanes live back to back in one flat vector; the root is the last lane.
  localparam int TOTAL  = level_offset(NUM_IN, LEVELS) + 1;

  `DP_CHECK_OUT_W(OUT_W, IN_W, LEVELS)

  logic [TOTAL*OUT_W-1:0]    node;
  logic [LEVELS:0]           vld;
  logic [2*(LEVELS+1)-1:0]   side;   // {acc_mode, acc_clr} travelling with each beat

  // Level-0 lanes: masked, then zero-extended to the result width.
  for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
    assign node[i*OUT_W +: OUT_W] =
      in_mask[i] ? {{(OUT_W-IN_W){1'b0}}, `DP_LANE(in_data, i, IN_W)} : '0;
  end

  assign vld[0]     = in_valid;
  assign side[1:0]  = {acc_mode, acc_clr};

  for (genvar k = 0; k < LEVELS; k++) begin : g_level
    localparam int N_K   = lanes_at_level(NUM_IN, k);
    localparam int N_O   = (N_K + 1) / 2;
    localparam int OFF_I = level_offset(NUM_IN, k);
    localparam int OFF_O = level_offset(NUM_IN, k + 1);

    sum_tree_level #(
      .N_IN   (N_K),
      .W      (OUT_W),
      .SIDE_W (2)
    ) u_level (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (vld[k]),
      .in_data   (node[OFF_I*OUT_W +: N_K*OUT_W]),
      .in_side   (side[2*k +: 2]),
      .out_valid (vld[k+1]),
      .out_data  (node[OFF_O*OUT_W +: N_O*OUT_W]),
      .out_side  (side[2*(k+1) +: 2])
    );
  end

  logic [OUT_W-1:0] tree;
  logic             tree_vld;
  logic             tree_mode;
  logic             tree_clr;
  logic [OUT_W:0]   acc_sum;

  assign tree      = node[(TOTAL-1)*OUT_W +: OUT_W];
  assign tree_vld  = vld[LEVELS];
  assign tree_mode = side[2*LEVELS + 1];
  assign tree_clr  = side[2*LEVELS];

  // sum_out doubles as the accumulator: every rule leaves accumulator == sum_out.
  assign acc_sum = {1'b0, sum_out} + {1'b0, tree};

  // Output stage: plain sum, restart, or saturating accumulate with sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum_out   <= '0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= tree_vld;
      if (tree_vld) begin
        if (!tree_mode) begin
          sum_out <= tree;
        end else if (tree_clr) begin
          sum_out <= tree;
          ovf     <= 1'b0;
        end else if (acc_sum[OUT_W]) begin
          sum_out <= '1;
          ovf     <= 1'b1;
        end else begin
          sum_out <= acc_sum[OUT_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_sum_tree.sv
// Bench for pipelined_sum_tree: a 32-bit and a 12-bit result instance share stimulus.
// Expected results are scheduled per output cycle and compared every cycle.
// Stimulus: fixed vector table, a reset-in-flight sequence, then random beats.
module tb_pipelined_sum_tree;

  localparam int NUM_IN = 16;
  localparam int IN_W   = 8;
  localparam int LAT    = 5;

  typedef struct packed {
    logic [31:0] sum32;
    logic        ovf32;
    logic [11:0] sum12;
    logic        ovf12;
  } exp_t;

  typedef struct {
    logic [127:0] data;
    logic [15:0]  mask;
    logic         mode;
    logic         clr;
    int           gap;
    exp_t         e;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [127:0] in_data = '0;
  logic [15:0]  in_mask = '0;
  logic         acc_mode = 1'b0;
  logic         acc_clr = 1'b0;
  logic         out_valid32, out_valid12;
  logic [31:0]  sum_out32;
  logic [11:0]  sum_out12;
  logic         ovf32, ovf12;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  exp_t sched [int];
  logic [31:0] last_sum32 = '0;
  logic [11:0] last_sum12 = '0;
  logic        last_ovf32 = 1'b0;
  logic        last_ovf12 = 1'b0;

  // Reference accumulator state, one per result width.
  longint m_acc32 = 0;
  longint m_acc12 = 0;
  logic   m_ovf32 = 1'b0;
  logic   m_ovf12 = 1'b0;

  pipelined_sum_tree #(.NUM_IN(NUM_IN), .IN_W(IN_W), .OUT_W(32)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_mask(in_mask),
    .acc_mode(acc_mode), .acc_clr(acc_clr),
    .out_valid(out_valid32), .sum_out(sum_out32), .ovf(ovf32)
  );

  pipelined_sum_tree #(.NUM_IN(NUM_IN), .IN_W(IN_W), .OUT_W(12)) u_dut12 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_mask(in_mask),
    .acc_mode(acc_mode), .acc_clr(acc_clr),
    .out_valid(out_valid12), .sum_out(sum_out12), .ovf(ovf12)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, got, exp);
    end
  endtask

  // Saturating accumulate rule for one result width, on plain integers.
  function automatic void acc_rule(input longint tree, input logic mo, input logic cl,
                                   input int w, inout longint acc, inout logic ov);
    longint lim;
    lim = (longint'(1) << w) - 1;
    if (!mo) begin
      acc = tree;
    end else if (cl) begin
      acc = tree;
      ov  = 1'b0;
    end else if (acc + tree > lim) begin
      acc = lim;
      ov  = 1'b1;
    end else begin
      acc = acc + tree;
    end
  endfunction

  function automatic exp_t model_beat(input logic [127:0] d, input logic [15:0] m,
                                      input logic mo, input logic cl);
    longint tree;
    exp_t   e;
    tree = 0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (m[i]) tree += longint'(d[i*IN_W +: IN_W]);
    end
    acc_rule(tree, mo, cl, 32, m_acc32, m_ovf32);
    acc_rule(tree, mo, cl, 12, m_acc12, m_ovf12);
    e.sum32 = m_acc32[31:0];
    e.ovf32 = m_ovf32;
    e.sum12 = m_acc12[11:0];
    e.ovf12 = m_ovf12;
    return e;
  endfunction

  task automatic drive(input logic [127:0] d, input logic [15:0] m, input logic mo,
                       input logic cl, input exp_t e);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_mask  = m;
    acc_mode = mo;
    acc_clr  = cl;
    sched[cyc + LAT] = e;
  endtask

  // Bubbles carry junk on the data/control inputs; the DUT must ignore it.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_mask  = 16'($urandom());
      acc_mode = 1'($urandom_range(0, 1));
      acc_clr  = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_acc32 = 0;
    m_acc12 = 0;
    m_ovf32 = 1'b0;
    m_ovf12 = 1'b0;
  endtask

  // Per-cycle monitor: scheduled beats must appear exactly then; otherwise outputs hold.
  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    if (rst) begin
      sched.delete();
      last_sum32 = '0;
      last_sum12 = '0;
      last_ovf32 = 1'b0;
      last_ovf12 = 1'b0;
    end else if (sched.exists(cyc)) begin
      e = sched[cyc];
      sched.delete(cyc);
      chk("out_valid32", longint'(out_valid32), 1);
      chk("out_valid12", longint'(out_valid12), 1);
      chk("sum32", longint'(sum_out32), longint'(e.sum32));
      chk("ovf32", longint'(ovf32), longint'(e.ovf32));
      chk("sum12", longint'(sum_out12), longint'(e.sum12));
      chk("ovf12", longint'(ovf12), longint'(e.ovf12));
      last_sum32 = e.sum32;
      last_sum12 = e.sum12;
      last_ovf32 = e.ovf32;
      last_ovf12 = e.ovf12;
    end else begin
      chk("idle_valid32", longint'(out_valid32), 0);
      chk("idle_valid12", longint'(out_valid12), 0);
      chk("hold_sum32", longint'(sum_out32), longint'(last_sum32));
      chk("hold_sum12", longint'(sum_out12), longint'(last_sum12));
      chk("hold_ovf32", longint'(ovf32), longint'(last_ovf32));
      chk("hold_ovf12", longint'(ovf12), longint'(last_ovf12));
    end
  end

  initial begin : main
    vec_t         tbl [13];
    logic [127:0] all_ff, all_1, all_10, ramp, d;
    logic [15:0]  m;
    logic         mo, cl;
    exp_t         e;

    for (int i = 0; i < NUM_IN; i++) begin
      all_ff[i*IN_W +: IN_W] = 8'hFF;
      all_1[i*IN_W +: IN_W]  = 8'd1;
      all_10[i*IN_W +: IN_W] = 8'd10;
      ramp[i*IN_W +: IN_W]   = 8'(i);
    end

    //           data    mask      mode  clr   gap  {sum32,  ovf32, sum12, ovf12}
    tbl[0]  = '{all_ff, 16'hFFFF, 1'b0, 1'b0, 6, '{32'd4080,  1'b0, 12'd4080, 1'b0}};
    tbl[1]  = '{ramp,   16'hFFFF, 1'b0, 1'b0, 0, '{32'd120,   1'b0, 12'd120,  1'b0}};
    tbl[2]  = '{all_1,  16'hFFFF, 1'b0, 1'b0, 2, '{32'd16,    1'b0, 12'd16,   1'b0}};
    tbl[3]  = '{all_10, 16'h00FF, 1'b0, 1'b0, 3, '{32'd80,    1'b0, 12'd80,   1'b0}};
    tbl[4]  = '{all_10, 16'h00FF, 1'b0, 1'b0, 2, '{32'd80,    1'b0, 12'd80,   1'b0}};
    tbl[5]  = '{all_1,  16'hFFFF, 1'b1, 1'b1, 0, '{32'd16,    1'b0, 12'd16,   1'b0}};
    tbl[6]  = '{all_1,  16'hFFFF, 1'b1, 1'b0, 0, '{32'd32,    1'b0, 12'd32,   1'b0}};
    tbl[7]  = '{all_1,  16'hFFFF, 1'b1, 1'b0, 0, '{32'd48,    1'b0, 12'd48,   1'b0}};
    tbl[8]  = '{all_1,  16'hFFFF, 1'b1, 1'b0, 4, '{32'd64,    1'b0, 12'd64,   1'b0}};
    tbl[9]  = '{all_ff, 16'hFFFF, 1'b1, 1'b1, 0, '{32'd4080,  1'b0, 12'd4080, 1'b0}};
    tbl[10] = '{all_ff, 16'hFFFF, 1'b1, 1'b0, 0, '{32'd8160,  1'b0, 12'd4095, 1'b1}};
    tbl[11] = '{all_ff, 16'hFFFF, 1'b1, 1'b0, 0, '{32'd12240, 1'b0, 12'd4095, 1'b1}};
    tbl[12] = '{all_ff, 16'hFFFF, 1'b1, 1'b1, 6, '{32'd4080,  1'b0, 12'd4080, 1'b0}};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(3);
    chk("reset_sum32", longint'(sum_out32), 0);
    chk("reset_ovf12", longint'(ovf12), 0);

    // Table vectors: the bench's accumulator state follows the tabled results.
    for (int t = 0; t < 13; t++) begin
      drive(tbl[t].data, tbl[t].mask, tbl[t].mode, tbl[t].clr, tbl[t].e);
      m_acc32 = longint'(tbl[t].e.sum32);
      m_ovf32 = tbl[t].e.ovf32;
      m_acc12 = longint'(tbl[t].e.sum12);
      m_ovf12 = tbl[t].e.ovf12;
      idle(tbl[t].gap);
    end

    // Saturate the 12-bit instance, then reset with a beat in flight.
    e = model_beat(all_ff, 16'hFFFF, 1'b1, 1'b0);
    drive(all_ff, 16'hFFFF, 1'b1, 1'b0, e);
    idle(1);
    pulse_rst();
    idle(LAT + 3);
    chk("post_rst_sum32", longint'(sum_out32), 0);
    chk("post_rst_ovf12", longint'(ovf12), 0);
    e = model_beat(all_1 + all_1 + all_1, 16'hFFFF, 1'b0, 1'b0);
    drive(all_1 + all_1 + all_1, 16'hFFFF, 1'b0, 1'b0, e);
    e = model_beat(all_1, 16'hFFFF, 1'b1, 1'b0);
    drive(all_1, 16'hFFFF, 1'b1, 1'b0, e);
    idle(LAT + 2);

    // Random beats against the reference model.
    repeat (400) begin
      if ($urandom_range(0, 3) != 0) begin
        d  = {$urandom(), $urandom(), $urandom(), $urandom()};
        m  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom());
        mo = 1'($urandom_range(0, 1));
        cl = mo & ($urandom_range(0, 3) == 0);
        e  = model_beat(d, m, mo, cl);
        drive(d, m, mo, cl, e);
      end else begin
        idle(1);
      end
    end
    idle(LAT + 3);

    chk("pending_beats", longint'(sched.num()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
